// File: rtl/demux_pkg.sv
// Shared types and constants for the 8-lane sequential demultiplexer.
package demux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {FILL, HOLD} demux_state_t;
  typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/demux_eight_seq_if.sv
// Lane-word input and frame output handshake bundle for demux_eight_seq.
interface demux_eight_seq_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   din_ready;
  lane_sel_t              s;
  logic                   s_load;
  logic [LANES*WIDTH-1:0] result;
  logic                   frame_valid;
  logic                   frame_ready;

  modport master (
    output din, din_valid, s, s_load, frame_ready,
    input  din_ready, result, frame_valid
  );

  modport slave (
    input  din, din_valid, s, s_load, frame_ready,
    output din_ready, result, frame_valid
  );
endinterface

// File: rtl/demux_ptr_cnt.sv
// Write-lane pointer: optional load, increment on accept, wrap flag when lane 7 is written.
module demux_ptr_cnt
  import demux_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  lane_sel_t load_val,
  input  logic      inc,
  output lane_sel_t sel,
  output logic      wrap
);
  lane_sel_t ptr_q;

  // A load takes effect in the same cycle, so a concurrent write lands at the loaded lane.
  assign sel  = load ? load_val : ptr_q;
  assign wrap = inc && (sel == lane_sel_t'(LANES - 1));

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load || inc) begin
      ptr_q <= sel + lane_sel_t'(inc);
    end
  end
endmodule

// File: rtl/demux_eight_seq.sv
// Sequential 1-to-8 demultiplexer: collects lane words into a frame and presents it with valid/ready.
// Build option: define DEMUX_CLEAR_EN to zero the other lanes on the first write of each frame.
module demux_eight_seq
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic               clk,
  input logic               rst_n,
  demux_eight_seq_if.slave  bus
);
  demux_state_t           state_q, state_d;
  logic [LANES*WIDTH-1:0] lanes_q, lanes_d;
  logic                   din_ready;
  logic                   accept;
  logic                   handoff;
  logic                   load;
  lane_sel_t              load_val;
  lane_sel_t              sel;
  logic                   wrap;
  logic                   clear_other;

  // In HOLD the consumer's ready is passed back so a word can enter lane 0 during the handoff.
  assign din_ready = (state_q == FILL) ? 1'b1 : bus.frame_ready;
  assign accept    = bus.din_valid && din_ready;
  assign handoff   = (state_q == HOLD) && bus.frame_ready;
  assign load      = handoff || ((state_q == FILL) && bus.s_load);
  assign load_val  = handoff ? '0 : bus.s;

  demux_ptr_cnt u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .inc      (accept),
    .sel      (sel),
    .wrap     (wrap)
  );

`ifdef DEMUX_CLEAR_EN
  logic first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
    end else if (accept) begin
      first_q <= 1'b0;
    end else if (load) begin
      first_q <= 1'b1;
    end
  end

  assign clear_other = handoff || ((state_q == FILL) && (first_q || bus.s_load));
`else
  assign clear_other = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && wrap) state_d = HOLD;
      HOLD:    if (handoff)        state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    lanes_d = lanes_q;
    if (accept) begin
      if (clear_other) lanes_d = '0;
      for (int k = 0; k < LANES; k++) begin
        if (sel == lane_sel_t'(k)) lanes_d[k*WIDTH +: WIDTH] = bus.din;
      end
    end
  end

  // NOTE: the lane bank is small and visible on result, so it is reset like any control flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
    end
  end

  assign bus.din_ready   = din_ready;
  assign bus.result      = lanes_q;
  assign bus.frame_valid = (state_q == HOLD);
endmodule

// File: tb/tb_demux_eight_seq.sv
// Scoreboard bench for demux_eight_seq (WIDTH=1); honours DEMUX_CLEAR_EN when defined.
module tb_demux_eight_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  demux_eight_seq_if #(.WIDTH(1)) bus ();

  demux_eight_seq #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state and expected-frame scoreboard.
  logic [7:0] m_lanes;
  int         m_ptr;
  logic       m_hold;
  logic       m_first;
  logic       fv_prev;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lanes = '0;
    m_ptr   = 0;
    m_hold  = 1'b0;
    m_first = 1'b1;
    fv_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs, check din_ready, clock, update model, check outputs.
  task automatic step(input logic dv, input logic d, input logic sl,
                      input logic [2:0] sv, input logic fr);
    logic       acc;
    logic [2:0] w;
    logic [7:0] exp_frame;
    bus.din_valid   = dv;
    bus.din         = d;
    bus.s_load      = sl;
    bus.s           = sv;
    bus.frame_ready = fr;
    #1;
    check("din_ready", 32'(bus.din_ready), 32'(m_hold ? fr : 1'b1));
    acc = dv && (m_hold ? fr : 1'b1);
    @(posedge clk);
    if (!m_hold) begin
      w = sl ? sv : 3'(m_ptr);
      if (acc) begin
`ifdef DEMUX_CLEAR_EN
        if (m_first || sl) m_lanes = '0;
`endif
        m_lanes[w] = d;
        m_first = 1'b0;
        if (w == 3'd7) begin
          m_hold = 1'b1;
          m_ptr  = 0;
          exp_q.push_back(m_lanes);
        end else begin
          m_ptr = int'(w) + 1;
        end
      end else if (sl) begin
        m_ptr   = int'(sv);
        m_first = 1'b1;
      end
    end else if (fr) begin
      m_hold  = 1'b0;
      m_ptr   = 0;
      m_first = 1'b1;
      if (acc) begin
`ifdef DEMUX_CLEAR_EN
        m_lanes = '0;
`endif
        m_lanes[0] = d;
        m_ptr      = 1;
        m_first    = 1'b0;
      end
    end
    #1;
    check("frame_valid", 32'(bus.frame_valid), 32'(m_hold));
    if (bus.frame_valid && !fv_prev) begin
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        exp_frame = exp_q.pop_front();
        check("sb_frame", 32'(bus.result), 32'(exp_frame));
      end
    end else if (bus.frame_valid) begin
      check("result_hold", 32'(bus.result), 32'(m_lanes));
    end
    fv_prev = bus.frame_valid;
  endtask

  initial begin
    logic [7:0] pat;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    bus.s_load      = 1'b0;
    bus.s           = '0;
    bus.frame_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_fv", 32'(bus.frame_valid), 32'd0);
    check("rst_din_ready", 32'(bus.din_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame by auto-increment; lane k receives the k-th word.
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 3'd0, 1'b0);
    check("t1_result", 32'(bus.result), 32'h4D);

    // Handoff with a same-cycle word that opens the next frame at lane 0.
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    check("t2_lane0", 32'(bus.result[0]), 32'd1);

    // Two more lanes, then jump to lane 6 and finish with lane 7.
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd6, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
`ifdef DEMUX_CLEAR_EN
    check("t3_result", 32'(bus.result), 32'hC0);
`else
    check("t3_result", 32'(bus.result), 32'hCD);
`endif
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Load-only pointer move, then six accepts fill lanes 2..7.
    step(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    pat = 8'b0010_1100;
    for (int i = 0; i < 6; i++) step(1'b1, pat[i], 1'b0, 3'd0, 1'b0);
    check("t4_fv", 32'(bus.frame_valid), 32'd1);

    // Held frame must not move while the consumer stalls, even with s_load and din traffic.
    for (int i = 0; i < 20; i++) step(1'(i % 2), 1'(i % 3 == 0), 1'(i % 5 == 0), 3'(i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Reset mid-frame, then a fresh full frame.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_result", 32'(bus.result), 32'd0);
    check("t5_fv", 32'(bus.frame_valid), 32'd0);
    check("t5_din_ready", 32'(bus.din_ready), 32'd1);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 3'd0, 1'b0);
    check("t5_frame_fv", 32'(bus.frame_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
